// File: rtl/audio_codec_config_sequencer_if.sv
// audio_codec_config_sequencer_if: config bus pins, volume handshake and status (master = sequencer, slave = codec/UI side)
interface audio_codec_config_sequencer_if;
  logic i2c_sclk;
  logic i2c_sdat_oe;
  logic i2c_sdat_in;
  logic vol_valid;
  logic vol_ready;
  logic [6:0] vol_level;
  logic busy;
  logic config_done;
  logic ack_error;
  modport master (
    output i2c_sclk, i2c_sdat_oe, vol_ready, busy, config_done, ack_error,
    input i2c_sdat_in, vol_valid, vol_level
  );
  modport slave (
    input i2c_sclk, i2c_sdat_oe, vol_ready, busy, config_done, ack_error,
    output i2c_sdat_in, vol_valid, vol_level
  );
endinterface

// File: rtl/audio_codec_config_sequencer.sv
// audio_codec_config_sequencer: writes the WM8731 init table over the two-wire config bus, then serves volume writes (ports: clk_clk, reset_reset, bus master side)
module audio_codec_config_sequencer #(
  parameter int CLK_DIV = 125,
  parameter int INIT_DELAY = 1000,
  parameter int GAP_CYCLES = 200,
  parameter int RETRIES = 2
) (
  input logic clk_clk,
  input logic reset_reset,
  audio_codec_config_sequencer_if.master bus
);
  localparam logic [2:0] WAIT = 3'd0, START = 3'd1, BITS = 3'd2, STOP = 3'd3, GAP = 3'd4, DONE = 3'd5;
  localparam int M1 = INIT_DELAY > GAP_CYCLES ? INIT_DELAY : GAP_CYCLES;
  localparam int CMAX = M1 > CLK_DIV ? M1 : CLK_DIV;
  localparam int CW = $clog2(CMAX + 1);
  localparam int RW = $clog2(RETRIES + 2);
  localparam logic [15:0] TABLE [8] = '{
    {7'd15, 9'h000}, {7'd6, 9'h067}, {7'd4, 9'h010}, {7'd5, 9'h000},
    {7'd7, 9'h002}, {7'd8, 9'h000}, {7'd2, 9'h179}, {7'd9, 9'h001}
  };
  logic [2:0] state, idx;
  logic [CW-1:0] cnt;
  logic [1:0] q;
  logic [4:0] slot;
  logic [26:0] sr;
  logic [RW-1:0] rc;
  logic [6:0] vol_lat;
  logic [15:0] word;
  logic nack, vol_mode, sclk, oe, done_r, err, cnt_end, ack_slot;
  always_comb begin
    cnt_end = cnt == (state == WAIT ? CW'(INIT_DELAY - 1) : state == GAP ? CW'(GAP_CYCLES - 1) : CW'(CLK_DIV - 1));
    word = vol_mode ? {7'd2, 2'b10, vol_lat} : TABLE[idx];
    ack_slot = slot == 5'd8 || slot == 5'd17 || slot == 5'd26;
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= WAIT;
      cnt <= '0;
      q <= '0;
      slot <= '0;
      sr <= '0;
      idx <= '0;
      rc <= '0;
      vol_lat <= '0;
      nack <= 1'b0;
      vol_mode <= 1'b0;
      sclk <= 1'b1;
      oe <= 1'b0;
      done_r <= 1'b0;
      err <= 1'b0;
    end else begin
      cnt <= (cnt_end || state == DONE) ? '0 : cnt + 1'b1;
      case (state)
        WAIT: if (cnt_end) begin
          state <= START;
          q <= '0;
        end
        START: if (cnt_end) begin
          q <= q + 1'b1;
          if (q == 2'd0) oe <= 1'b1;
          else begin
            sclk <= 1'b0;
            state <= BITS;
            q <= '0;
            slot <= '0;
            sr <= {8'h34, 1'b1, word[15:8], 1'b1, word[7:0], 1'b1};
          end
        end
        BITS: if (cnt_end) begin
          q <= q + 1'b1;
          case (q)
            2'd0: oe <= ~sr[26];
            2'd1: sclk <= 1'b1;
            2'd2: if (ack_slot && bus.i2c_sdat_in) nack <= 1'b1;
            default: begin
              sclk <= 1'b0;
              sr <= sr << 1;
              slot <= slot + 1'b1;
              if (nack || slot == 5'd26) begin
                state <= STOP;
                q <= '0;
              end
            end
          endcase
        end
        STOP: if (cnt_end) begin
          q <= q + 1'b1;
          if (q == 2'd0) oe <= 1'b1;
          else if (q == 2'd1) sclk <= 1'b1;
          else begin
            oe <= 1'b0;
            state <= GAP;
          end
        end
        GAP: if (cnt_end) begin
          q <= '0;
          nack <= 1'b0;
          if (nack && rc < RW'(RETRIES)) begin
            rc <= rc + 1'b1;
            state <= START;
          end else begin
            rc <= '0;
            err <= err | nack;
            if (vol_mode || idx == 3'd7) begin
              state <= DONE;
              done_r <= 1'b1;
              vol_mode <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
              state <= START;
            end
          end
        end
        DONE: if (bus.vol_valid) begin
          vol_lat <= bus.vol_level;
          vol_mode <= 1'b1;
          state <= START;
          q <= '0;
        end
        default: state <= WAIT;
      endcase
    end
  end
  assign bus.i2c_sclk = sclk;
  assign bus.i2c_sdat_oe = oe;
  assign bus.vol_ready = state == DONE;
  assign bus.busy = state == START || state == BITS || state == STOP;
  assign bus.config_done = done_r;
  assign bus.ack_error = err;
endmodule

// File: tb/tb_audio_codec_config_sequencer.sv
// tb_audio_codec_config_sequencer: decodes the config bus into frames and scores them against expected frames
module tb_audio_codec_config_sequencer;
  localparam int CLK_DIV = 4, INIT_DELAY = 20, GAP_CYCLES = 10, RETRIES = 2;
  typedef struct packed { logic [7:0] b1, b2, b3; logic [4:0] nbits; } frame_t;
  typedef struct packed { logic [7:0] b2, b3; } init_t;
  typedef struct packed { logic [6:0] lvl; logic [7:0] b2, b3; } vol_t;
  logic clk_clk = 0, reset_reset = 1, ack_pull = 0, p_scl = 1, p_oe = 0, in_frame = 0, hit = 0;
  int n_cmp = 0, n_bad = 0, cyc = 0, nb = 0, last_rise = -1, per_err = 0, frames_seen = 0, nack_left = 0, n = 0, lat = 0;
  logic [7:0] nack_b2 = 8'h0C;
  logic [31:0] sr = 0, al = 0;
  frame_t exp_q[$];
  frame_t e;
  init_t init_tab [8];
  vol_t vol_tab [4];
  audio_codec_config_sequencer_if bus();
  audio_codec_config_sequencer #(.CLK_DIV(CLK_DIV), .INIT_DELAY(INIT_DELAY), .GAP_CYCLES(GAP_CYCLES), .RETRIES(RETRIES)) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .bus(bus)
  );
  always #5 clk_clk = ~clk_clk;
  assign bus.i2c_sdat_in = ~(bus.i2c_sdat_oe | ack_pull);
  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push_f(logic [7:0] x2, logic [7:0] x3, int nbits);
    exp_q.push_back('{b1: 8'h34, b2: x2, b3: x3, nbits: 5'(nbits)});
  endtask
  task automatic push_init(int lo, int hi);
    for (int i = lo; i <= hi; i++) push_f(init_tab[i].b2, init_tab[i].b3, 27);
  endtask
  task automatic do_reset();
    reset_reset = 1;
    exp_q.delete();
    nack_left = 0;
    repeat (2) @(posedge clk_clk);
    #1;
    frames_seen = 0;
    reset_reset = 0;
  endtask
  task automatic check_reset();
    check("rst_sclk", bus.i2c_sclk, 1);
    check("rst_oe", bus.i2c_sdat_oe, 0);
    check("rst_vol_ready", bus.vol_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_config_done", bus.config_done, 0);
    check("rst_ack_error", bus.ack_error, 0);
  endtask
  task automatic wait_cfg();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_clk);
      if (bus.config_done) break;
    end
    check("config_done_wait", bus.config_done, 1);
  endtask
  task automatic wait_ready();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_clk);
      if (bus.vol_ready) break;
    end
    check("vol_ready_wait", bus.vol_ready, 1);
  endtask
  initial forever begin
    @(negedge clk_clk);
    cyc++;
    if (reset_reset) begin
      in_frame = 0;
      nb = 0;
      ack_pull = 0;
    end else if (!p_oe && bus.i2c_sdat_oe && p_scl && bus.i2c_sclk) begin
      in_frame = 1;
      nb = 0;
      sr = 0;
      per_err = 0;
      last_rise = -1;
    end else if (in_frame && p_oe && !bus.i2c_sdat_oe && p_scl && bus.i2c_sclk) begin
      n = nb - 1;
      al = (n >= 0 && n <= 27) ? (sr >> 1) << (27 - n) : sr >> 1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_frame: got %02h %02h %02h (%0d bits), expected none", al[26:19], al[17:10], al[8:1], n);
      end else begin
        e = exp_q.pop_front();
        check("frame_bits", n, int'(e.nbits));
        check("frame_b1", int'(al[26:19]), int'(e.b1));
        check("frame_b2", int'(al[17:10]), int'(e.b2));
        check("frame_b3", int'(al[8:1]), int'(e.b3));
        check("sclk_period", per_err, 0);
      end
      frames_seen++;
      in_frame = 0;
      ack_pull = 0;
    end else if (in_frame && !p_scl && bus.i2c_sclk) begin
      if (last_rise >= 0 && cyc - last_rise != 4 * CLK_DIV) per_err++;
      last_rise = cyc;
      sr = {sr[30:0], bus.i2c_sdat_in};
      nb++;
    end else if (in_frame && p_scl && !bus.i2c_sclk) begin
      hit = nb == 17 && sr[7:0] == nack_b2 && nack_left > 0;
      if (hit) nack_left--;
      ack_pull = nb == 8 || nb == 26 || (nb == 17 && !hit);
    end
    p_scl = bus.i2c_sclk;
    p_oe = bus.i2c_sdat_oe;
  end
  initial begin
    init_tab[0] = '{b2: 8'h1E, b3: 8'h00};
    init_tab[1] = '{b2: 8'h0C, b3: 8'h67};
    init_tab[2] = '{b2: 8'h08, b3: 8'h10};
    init_tab[3] = '{b2: 8'h0A, b3: 8'h00};
    init_tab[4] = '{b2: 8'h0E, b3: 8'h02};
    init_tab[5] = '{b2: 8'h10, b3: 8'h00};
    init_tab[6] = '{b2: 8'h05, b3: 8'h79};
    init_tab[7] = '{b2: 8'h12, b3: 8'h01};
    vol_tab[0] = '{lvl: 7'h30, b2: 8'h05, b3: 8'h30};
    vol_tab[1] = '{lvl: 7'h7F, b2: 8'h05, b3: 8'h7F};
    vol_tab[2] = '{lvl: 7'h00, b2: 8'h05, b3: 8'h00};
    vol_tab[3] = '{lvl: 7'h55, b2: 8'h05, b3: 8'h55};
    bus.vol_valid = 0;
    bus.vol_level = 0;
    do_reset();
    check_reset();
    push_init(0, 7);
    lat = 0;
    for (int i = 1; i <= 500; i++) begin
      @(posedge clk_clk);
      #1;
      if (bus.i2c_sdat_oe) begin
        lat = i;
        break;
      end
    end
    check("start_latency", lat, INIT_DELAY + CLK_DIV);
    wait_cfg();
    check("ack_error_clean", bus.ack_error, 0);
    check("busy_idle", bus.busy, 0);
    check("sb_init", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      bus.vol_valid = 1;
      bus.vol_level = vol_tab[i].lvl;
      push_f(vol_tab[i].b2, vol_tab[i].b3, 27);
      @(posedge clk_clk);
      #1;
      check("vol_ready_drop", bus.vol_ready, 0);
      check("vol_busy", bus.busy, 1);
      bus.vol_valid = 0;
      bus.vol_level = 7'h2A;
      wait_ready();
      check("sb_vol", exp_q.size(), 0);
    end
    do_reset();
    check_reset();
    nack_left = 1;
    push_init(0, 0);
    push_f(8'h0C, 8'h00, 18);
    push_init(1, 7);
    wait_cfg();
    check("nack_once_ack_error", bus.ack_error, 0);
    check("nack_once_used", nack_left, 0);
    check("sb_nack_once", exp_q.size(), 0);
    bus.vol_valid = 1;
    bus.vol_level = 7'h11;
    do_reset();
    check_reset();
    nack_left = 100;
    push_init(0, 0);
    repeat (3) push_f(8'h0C, 8'h00, 18);
    push_init(2, 7);
    push_f(8'h05, 8'h11, 27);
    wait_cfg();
    @(posedge clk_clk);
    #1;
    check("held_vol_accept", bus.vol_ready, 0);
    bus.vol_valid = 0;
    check("nack_persist_ack_error", bus.ack_error, 1);
    wait_ready();
    check("sb_nack_persist", exp_q.size(), 0);
    do_reset();
    check_reset();
    push_init(0, 3);
    hit = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_clk);
      if (frames_seen == 3 && in_frame && nb == 12 && bus.i2c_sdat_oe && !bus.i2c_sclk) begin
        hit = 1;
        break;
      end
    end
    check("midframe_reached", hit, 1);
    reset_reset = 1;
    exp_q.delete();
    @(posedge clk_clk);
    #1;
    check("midrst_sclk", bus.i2c_sclk, 1);
    check("midrst_oe", bus.i2c_sdat_oe, 0);
    check("midrst_busy", bus.busy, 0);
    @(posedge clk_clk);
    #1;
    frames_seen = 0;
    reset_reset = 0;
    push_init(0, 0);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_clk);
      if (frames_seen >= 1) break;
    end
    check("restart_frames", frames_seen, 1);
    check("sb_restart", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
